// File: rtl/sramlike_axi_bridge.sv
// SRAM-like inst/data miss ports to a single AXI3 master, one single-beat transaction at a time.
// Optional macro BRIDGE_ARB_RR_EN selects round-robin arbitration instead of fixed data-over-inst priority.
module sramlike_axi_bridge #(
  parameter logic [3:0] ID_INST = 4'd0,
  parameter logic [3:0] ID_DATA = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR, WR_B, RESP} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;  // 1 = data port
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        aw_pend_q, aw_pend_d;
  logic        w_pend_q, w_pend_d;

  logic        pri_data;
  logic        grant_data, grant_inst;
  logic [1:0]  size_eff;

  // Response fields are never examined: the slave is assumed to answer OKAY in order.
  logic unused_inputs;
  assign unused_inputs = ^{rid, rresp, rlast, bid, bresp};

`ifdef BRIDGE_ARB_RR_EN
  logic last_grant_q, last_grant_d;  // 1 = data granted last
  assign pri_data = ~last_grant_q;
`else
  assign pri_data = 1'b1;
`endif

  // addr_ok is withheld while reset is asserted so no requester sees a phantom accept.
  always_comb begin
    grant_data = 1'b0;
    grant_inst = 1'b0;
    if (state_q == IDLE && resetn) begin
      grant_data = data_req & (~inst_req | pri_data);
      grant_inst = inst_req & ~grant_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    wr_d      = wr_q;
    size_d    = size_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
`ifdef BRIDGE_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_data || grant_inst) begin
          owner_d   = grant_data;
          wr_d      = grant_data & data_wr;
          size_d    = grant_data ? data_size : inst_size;
          addr_d    = grant_data ? data_addr : inst_addr;
          wdata_d   = data_wdata;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          state_d   = (grant_data & data_wr) ? WR : RD_A;
`ifdef BRIDGE_ARB_RR_EN
          last_grant_d = grant_data;
`endif
        end
      end
      RD_A: begin
        if (arready) state_d = RD_D;
      end
      RD_D: begin
        if (rvalid) begin
          rdata_d = rdata;
          state_d = RESP;
        end
      end
      WR: begin
        if (awready) aw_pend_d = 1'b0;
        if (wready)  w_pend_d  = 1'b0;
        // Either handshake may have completed in an earlier cycle.
        if ((~aw_pend_q | awready) && (~w_pend_q | wready)) state_d = WR_B;
      end
      WR_B: begin
        if (bvalid) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      wr_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
`ifdef BRIDGE_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wr_q      <= wr_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
`ifdef BRIDGE_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    size_eff = (size_q == 2'b11) ? 2'b10 : size_q;
    case (size_eff)
      2'b00:   wstrb = 4'b0001 << addr_q[1:0];
      2'b01:   wstrb = addr_q[1] ? 4'b1100 : 4'b0011;
      default: wstrb = 4'b1111;
    endcase
  end

  assign inst_addr_ok = grant_inst;
  assign data_addr_ok = grant_data;
  assign inst_data_ok = (state_q == RESP) & ~owner_q;
  assign data_data_ok = (state_q == RESP) & owner_q;
  assign inst_rdata   = (state_q == RESP && !owner_q && !wr_q) ? rdata_q : '0;
  assign data_rdata   = (state_q == RESP &&  owner_q && !wr_q) ? rdata_q : '0;

  assign arid    = owner_q ? ID_DATA : ID_INST;
  assign araddr  = addr_q;
  assign arsize  = {1'b0, size_eff};
  assign arvalid = (state_q == RD_A);
  assign rready  = (state_q == RD_D);
  assign arlen   = '0;
  assign arburst = 2'b01;
  assign arlock  = '0;
  assign arcache = '0;
  assign arprot  = '0;

  assign awid    = ID_DATA;
  assign awaddr  = addr_q;
  assign awsize  = {1'b0, size_eff};
  assign awvalid = (state_q == WR) & aw_pend_q;
  assign awlen   = '0;
  assign awburst = 2'b01;
  assign awlock  = '0;
  assign awcache = '0;
  assign awprot  = '0;

  assign wid     = ID_DATA;
  assign wdata   = wdata_q;
  assign wlast   = 1'b1;
  assign wvalid  = (state_q == WR) & w_pend_q;
  assign bready  = (state_q == WR_B);

endmodule
